// File: rtl/axioma_mem_master.sv
// rtl/axioma_mem_master.sv - byte-serial CPU load/store master with pointer update
// Splits 8/16-bit accesses into little-endian byte transfers toward an SRAM controller.
module axioma_mem_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_ptr_mode,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic [15:0] resp_ptr,
  output logic        resp_error,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  input  logic        mem_error
);

  typedef enum logic [2:0] {
    IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, DONE
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          is_wide, is_store, err_q, resp_error_q;
  logic [7:0]    wdata_hi;
  logic [15:0]   ptr_q, acc, resp_rdata_q, resp_ptr_q;
  logic [15:0]   size, eff_addr, new_ptr;
  logic          accept, in_wait, byte_done, timed_out, issuing;

  assign accept    = req_valid && (state == IDLE);
  assign in_wait   = (state == WAIT_LO) || (state == WAIT_HI);
  // wait_cnt == 0 marks the guard cycle, where mem_ready is not trusted yet
  assign byte_done = in_wait && (wait_cnt != '0) && mem_ready;
  assign timed_out = in_wait && !byte_done && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign issuing   = (state == ISSUE_LO) || (state == ISSUE_HI);

  assign size     = req_op[1] ? 16'd2 : 16'd1;
  assign eff_addr = (req_ptr_mode == 2'b10) ? req_addr - size : req_addr;
  assign new_ptr  = (req_ptr_mode == 2'b10) ? eff_addr :
                    (req_ptr_mode == 2'b01) ? req_addr + size : req_addr;

  assign req_ready  = (state == IDLE);
  assign mem_read   = issuing && !is_store;
  assign mem_write  = issuing && is_store;
  assign resp_valid = (state == DONE);
  // Result is visible straight from the accumulator in DONE, then held until the next DONE
  assign resp_rdata = (state == DONE) ? acc   : resp_rdata_q;
  assign resp_ptr   = (state == DONE) ? ptr_q : resp_ptr_q;
  assign resp_error = (state == DONE) ? err_q : resp_error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = ISSUE_LO;
      ISSUE_LO: state_next = WAIT_LO;
      WAIT_LO: begin
        if (byte_done)      state_next = (mem_error || !is_wide) ? DONE : ISSUE_HI;
        else if (timed_out) state_next = DONE;
      end
      ISSUE_HI: state_next = WAIT_HI;
      WAIT_HI:  if (byte_done || timed_out) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt     <= '0;
      is_wide      <= 1'b0;
      is_store     <= 1'b0;
      wdata_hi     <= 8'h00;
      ptr_q        <= 16'h0000;
      acc          <= 16'h0000;
      err_q        <= 1'b0;
      mem_addr     <= 16'h0000;
      mem_wdata    <= 8'h00;
      resp_rdata_q <= 16'h0000;
      resp_ptr_q   <= 16'h0000;
      resp_error_q <= 1'b0;
    end else begin
      wait_cnt <= in_wait ? wait_cnt + CW'(1) : '0;
      if (accept) begin
        is_wide   <= req_op[1];
        is_store  <= req_op[0];
        wdata_hi  <= req_wdata[15:8];
        ptr_q     <= new_ptr;
        mem_addr  <= eff_addr;
        mem_wdata <= req_wdata[7:0];
        acc       <= 16'h0000;
        err_q     <= 1'b0;
      end
      if (byte_done) begin
        if (mem_error)              err_q      <= 1'b1;
        else if (state == WAIT_LO)  acc[7:0]   <= mem_rdata;
        else                        acc[15:8]  <= mem_rdata;
        if (state == WAIT_LO && !mem_error && is_wide) begin
          mem_addr  <= mem_addr + 16'd1;
          mem_wdata <= wdata_hi;
        end
      end
      if (timed_out) err_q <= 1'b1;
      if (state == DONE) begin
        resp_rdata_q <= acc;
        resp_ptr_q   <= ptr_q;
        resp_error_q <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_axioma_mem_master.sv
// tb/tb_axioma_mem_master.sv - scoreboard bench for axioma_mem_master
module tb_axioma_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_ptr_mode;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [15:0] resp_ptr;
  logic        resp_error;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        mem_error;

  logic        ready_en;
  logic        err_en;
  logic [15:0] err_addr;

  int checks = 0;
  int fails  = 0;

  typedef struct { logic wr; logic [15:0] addr; logic [7:0] data; } acc_t;
  typedef struct { logic [15:0] rdata; logic [15:0] ptr; logic err; int lat; logic chk_rdata; } rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];

  axioma_mem_master dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_ptr_mode(req_ptr_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_ptr(resp_ptr),
    .resp_error(resp_error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [15:0] a);
    if (a == 16'h0100) return 8'hA5;
    return (a[7:0] + 8'h11) ^ a[15:8];
  endfunction

  assign mem_rdata = pat(mem_addr);
  assign mem_ready = ready_en;
  assign mem_error = err_en && (mem_addr == err_addr);

  task automatic do_req(input logic [1:0] op, input logic [1:0] mode,
                        input logic [15:0] addr, input logic [15:0] wdata, input string name);
    logic [15:0] sz, eff, ptr, rd;
    logic        wide, st, elo, ehi, done, seen;
    logic [15:0] last_addr;
    logic [7:0]  last_wdata;
    acc_t        a;
    rsp_t        r;
    int          g;
    wide = op[1];
    st   = op[0];
    sz   = wide ? 16'd2 : 16'd1;
    eff  = (mode == 2'b10) ? addr - sz : addr;
    ptr  = (mode == 2'b10) ? eff : (mode == 2'b01) ? addr + sz : addr;
    elo  = (err_en && eff == err_addr) || !ready_en;
    ehi  = err_en && (eff + 16'd1) == err_addr;
    acc_q.push_back('{st, eff, wdata[7:0]});
    if (wide && !elo) acc_q.push_back('{st, eff + 16'd1, wdata[15:8]});
    rd[7:0]  = elo ? 8'h00 : pat(eff);
    rd[15:8] = (wide && !elo && !ehi) ? pat(eff + 16'd1) : 8'h00;
    r.rdata = rd;
    r.ptr   = ptr;
    r.err   = elo || (wide && ehi);
    r.lat   = !ready_en ? 18 : (!wide || elo) ? 4 : 7;
    r.chk_rdata = !st;
    rsp_q.push_back(r);

    g = 0;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_ptr_mode = mode; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_ptr_mode = 2'($urandom);
    req_addr = 16'($urandom); req_wdata = 16'($urandom);
    done = 1'b0; seen = 1'b0; last_addr = '0; last_wdata = '0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      checks++;
      if (mem_read && mem_write) begin
        fails++; $display("FAIL %s both_strobes cyc=%0d got=1 exp=0", name, cyc);
      end
      if (mem_read || mem_write) begin
        checks++;
        if (acc_q.size() == 0) begin
          fails++; $display("FAIL %s unexpected_strobe addr=%h exp=none", name, mem_addr);
        end else begin
          a = acc_q.pop_front();
          if (mem_write !== a.wr || mem_addr !== a.addr || (a.wr && mem_wdata !== a.data) || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s access got wr=%b addr=%h wdata=%h rdy=%b exp wr=%b addr=%h wdata=%h rdy=0",
                     name, mem_write, mem_addr, mem_wdata, req_ready, a.wr, a.addr, a.data);
          end
        end
        last_addr = mem_addr; last_wdata = mem_wdata; seen = 1'b1;
      end else if (resp_valid) begin
        done = 1'b1;
        r = rsp_q.pop_front();
        checks++;
        if (cyc != r.lat || resp_ptr !== r.ptr || resp_error !== r.err || (r.chk_rdata && resp_rdata !== r.rdata)) begin
          fails++;
          $display("FAIL %s response got lat=%0d ptr=%h err=%b rdata=%h exp lat=%0d ptr=%h err=%b rdata=%h",
                   name, cyc, resp_ptr, resp_error, resp_rdata, r.lat, r.ptr, r.err, r.rdata);
        end
      end else begin
        checks++;
        if (!seen || mem_addr !== last_addr || mem_wdata !== last_wdata || req_ready !== 1'b0) begin
          fails++;
          $display("FAIL %s wait_hold cyc=%0d got addr=%h wdata=%h rdy=%b exp addr=%h wdata=%h rdy=0",
                   name, cyc, mem_addr, mem_wdata, req_ready, last_addr, last_wdata);
        end
      end
    end
    checks++;
    if (!done) begin
      fails++; $display("FAIL %s no_response got=none exp=resp_valid", name);
    end else begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || resp_ptr !== r.ptr || resp_error !== r.err) begin
        fails++;
        $display("FAIL %s resp_hold got v=%b ptr=%h err=%b exp v=0 ptr=%h err=%b",
                 name, resp_valid, resp_ptr, resp_error, r.ptr, r.err);
      end
    end
    checks++;
    if (acc_q.size() != 0) begin
      fails++; $display("FAIL %s missing_access got=%0d exp=0 left", name, acc_q.size());
    end
    acc_q.delete();
    rsp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      fails++;
      $display("FAIL %s ctrl got rdy=%b v=%b rd=%b wr=%b exp 1 0 0 0", name, req_ready, resp_valid, mem_read, mem_write);
    end
    checks++;
    if (resp_error !== 1'b0 || resp_rdata !== 16'h0 || resp_ptr !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 8'h0) begin
      fails++;
      $display("FAIL %s data got err=%b rdata=%h ptr=%h addr=%h wdata=%h exp all zero",
               name, resp_error, resp_rdata, resp_ptr, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ld8();
    do_req(2'b00, 2'b00, 16'h0100, 16'h0000, "ld8_0100");
  endtask

  task automatic test_st16_predec();
    do_req(2'b11, 2'b10, 16'h08FF, 16'h1234, "st16_predec");
  endtask

  task automatic test_ld16_wrap();
    do_req(2'b10, 2'b01, 16'hFFFF, 16'h0000, "ld16_wrap");
  endtask

  task automatic test_modes();
    do_req(2'b01, 2'b01, 16'h4000, 16'hBEEF, "st8_postinc");
    do_req(2'b00, 2'b10, 16'h0000, 16'h0000, "ld8_predec_wrap");
    do_req(2'b10, 2'b11, 16'h1234, 16'h0000, "ld16_mode3");
    do_req(2'b11, 2'b00, 16'h7FFF, 16'hCAFE, "st16_none");
  endtask

  task automatic test_errors();
    err_en = 1'b1;
    err_addr = 16'h0500;
    do_req(2'b10, 2'b00, 16'h0500, 16'h0000, "ld16_err_lo");
    do_req(2'b10, 2'b00, 16'h04FF, 16'h0000, "ld16_err_hi");
    do_req(2'b01, 2'b00, 16'h0500, 16'h0077, "st8_err");
    err_en = 1'b0;
  endtask

  task automatic test_timeout();
    ready_en = 1'b0;
    do_req(2'b10, 2'b00, 16'h2000, 16'h0000, "ld16_timeout");
    ready_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int strobes;
    int bad;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_ptr_mode = 2'b00; req_addr = 16'h3000; req_wdata = 16'h0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    strobes = 0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (mem_read || mem_write) strobes++;
    end
    checks++;
    if (strobes != 2) begin
      fails++; $display("FAIL reset_mid strobes_before got=%0d exp=2", strobes);
    end
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid_async");
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (resp_valid || mem_read || mem_write) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++; $display("FAIL reset_mid stray_activity got=%0d exp=0", bad);
    end
    do_req(2'b10, 2'b01, 16'h3000, 16'h0000, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      do_req(2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), $sformatf("b2b_%0d", i));
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_op = '0; req_ptr_mode = '0; req_addr = '0; req_wdata = '0;
    ready_en = 1'b1; err_en = 1'b0; err_addr = '0;
    test_reset();
    test_ld8();
    test_st16_predec();
    test_ld16_wrap();
    test_modes();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
